// File: rtl/mem_dma_engine.sv
// mem_dma_engine
//   Burst transfer engine driving the data memory's external word port.
//   A command selects direction, first word address and length. Write
//   bursts move words from the s_* stream into memory; read bursts move
//   words from memory out on the m_* stream through a small return FIFO.
//
// Ports
//   clock, reset_n        : single rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_write             : 1 = stream->memory, 0 = memory->stream
//   cmd_addr, cmd_len     : first word address, length in words (0 = empty)
//   s_valid/s_ready/s_data: write-burst input stream
//   m_valid/m_ready/m_data: read-burst output stream
//   ext_valid/ext_write/ext_addr/ext_wdata/ext_rdata : memory port
//   busy                  : command accepted and not yet completed
//   done                  : one-cycle completion pulse
module mem_dma_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ext_valid,
    output logic                  ext_write,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    output logic [DATA_WIDTH-1:0] ext_wdata,
    input  logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  busy,
    output logic                  done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Reset asserts asynchronously but is released on a clock edge so all
    // state leaves reset in the same cycle.
    logic rst_meta_n;
    logic rst_sync_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    logic [1:0]            state;
    logic                  dir_write;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  busy_r;
    logic                  done_r;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      in_flight;
    logic                  vld_p1;

    logic                  cmd_fire;
    logic                  s_fire;
    logic                  m_pop;
    logic                  fifo_push;
    logic                  rd_issue;
    logic                  drain_exit;
    logic [CNT_W:0]        occupancy;

    // cmd_ready is held low during reset and in the done cycle so a new
    // command is only taken once the previous completion has been seen.
    assign cmd_ready = rst_sync_n && (state == ST_IDLE) && !done_r;
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign s_ready   = (state == ST_WRITE) && (remaining != '0);
    assign s_fire    = s_valid && s_ready;

    assign m_valid   = (fifo_count != '0);
    assign m_pop     = m_valid && m_ready;
    assign m_data    = m_valid ? fifo_mem[rd_ptr] : '0;

    assign fifo_push = vld_p1;

    // in_flight counts a read from the cycle it is decided, so the FIFO can
    // never be asked to hold more words than it has slots.
    assign occupancy = {1'b0, fifo_count} + {1'b0, in_flight};
    assign rd_issue  = (state == ST_READ) && (remaining != '0) &&
                       (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    // A write burst's DRAIN lasts exactly the cycle of the last ext write.
    // A read burst leaves once nothing is in flight and the final word is
    // being taken this cycle (or the FIFO is already empty).
    assign drain_exit = (state == ST_DRAIN) &&
                        (dir_write ||
                         ((in_flight == '0) &&
                          ((fifo_count == '0) ||
                           ((fifo_count == CNT_W'(1)) && m_pop))));

    assign busy = busy_r;
    assign done = done_r;

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= ST_IDLE;
            dir_write <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        dir_write <= cmd_write;
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            busy_r <= 1'b1;
                            state  <= cmd_write ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (s_fire) begin
                        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_issue) begin
                        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                default: begin
                    if (drain_exit) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // ---- stage p0: memory access presented on the ext port ----
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            ext_valid <= 1'b0;
            ext_write <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
        end else begin
            ext_valid <= s_fire || rd_issue;
            ext_write <= s_fire;
            if (s_fire || rd_issue) begin
                ext_addr <= cur_addr;
            end
            if (s_fire) begin
                ext_wdata <= s_data;
            end
        end
    end

    // ---- stage p1: read data valid on ext_rdata, pushed at end of cycle ----
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            vld_p1     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_flight  <= '0;
        end else begin
            vld_p1     <= ext_valid && !ext_write;
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (m_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(fifo_push) - CNT_W'(m_pop);
            in_flight  <= in_flight + CNT_W'(rd_issue) - CNT_W'(fifo_push);
        end
    end

    // ---- stage p2: FIFO storage, head presented on m_data ----
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= ext_rdata;
        end
    end

endmodule

// File: tb/tb_mem_dma_engine.sv
module tb_mem_dma_engine;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int LW = 13;
    localparam int FD = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          ext_valid;
    logic          ext_write;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [DW-1:0] ext_rdata;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    mem_dma_engine #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ext_valid(ext_valid), .ext_write(ext_write), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .busy(busy), .done(done)
    );

    // Data memory model: read data appears the cycle after the read and holds.
    logic [DW-1:0] mem    [0:4095];
    logic [DW-1:0] shadow [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        ext_rdata = '0;
    end
    always @(posedge clock) begin
        if (ext_valid) begin
            if (ext_write) mem[ext_addr] <= ext_wdata;
            else           ext_rdata     <= mem[ext_addr];
        end
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ext_t;

    ext_t          exp_ext [$];
    logic [DW-1:0] exp_m   [$];
    int            wr_cyc_q[$];
    int            rd_cyc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0, exp_done = 0;
    int done_cyc = 0, accept_cyc = 0, s_hs_count = 0;
    int rd_seen_burst = 0, first_rd_cyc = 0, last_rd_cyc = 0;
    int rd_total = 0, pop_total = 0;
    logic hold_prev = 1'b0, done_prev = 1'b0, busy_pending = 1'b0, strict_lat = 1'b0;
    logic [DW-1:0] hold_data = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares everything the DUT presents against the queues.
    always @(negedge clock) begin
        ext_t e;
        int   t;
        if (!reset_n) begin
            hold_prev    = 1'b0;
            done_prev    = 1'b0;
            busy_pending = 1'b0;
            rd_total     = 0;
            pop_total    = 0;
        end else begin
            if (done_prev)    chk("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
            if (busy_pending) chk("busy_after_accept", 32'(busy), 32'd1);
            busy_pending = 1'b0;
            if (cmd_valid && cmd_ready) begin
                accept_cyc   = cyc;
                busy_pending = (cmd_len != '0);
            end
            if (s_valid && s_ready) begin
                s_hs_count++;
                wr_cyc_q.push_back(cyc + 1);
            end
            if (ext_valid) begin
                if (exp_ext.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ext_unexpected: got addr %0h write %0b expected no access", ext_addr, ext_write);
                end else begin
                    e = exp_ext.pop_front();
                    chk("ext_write", 32'(ext_write), 32'(e.wr));
                    chk("ext_addr", 32'(ext_addr), 32'(e.addr));
                    if (e.wr) chk("ext_wdata", ext_wdata, e.data);
                end
                if (ext_write) begin
                    if (wr_cyc_q.size() == 0) fail_now("write_latency_no_handshake");
                    else begin
                        t = wr_cyc_q.pop_front();
                        chk("write_latency", 32'(cyc), 32'(t));
                    end
                end else begin
                    rd_total++;
                    rd_cyc_q.push_back(cyc);
                    chk("occupancy_le_depth", 32'(rd_total - pop_total <= FD), 32'd1);
                    if (rd_seen_burst == 0) first_rd_cyc = cyc;
                    last_rd_cyc = cyc;
                    rd_seen_burst++;
                end
            end
            if (hold_prev) begin
                chk("m_valid_held", 32'(m_valid), 32'd1);
                chk("m_data_held", m_data, hold_data);
            end
            if (m_valid && m_ready) begin
                pop_total++;
                if (exp_m.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_unexpected: got %0h expected no beat", m_data);
                end else begin
                    chk("m_data", m_data, exp_m.pop_front());
                end
                if (rd_cyc_q.size() != 0) begin
                    t = rd_cyc_q.pop_front();
                    if (strict_lat) chk("read_latency", 32'(cyc), 32'(t + 2));
                    else            chk("read_latency_min", 32'(cyc >= t + 2), 32'd1);
                end
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            if (done) begin
                done_count++;
                done_cyc = cyc;
                chk("busy_low_at_done", 32'(busy), 32'd0);
                chk("cmd_ready_low_at_done", 32'(cmd_ready), 32'd0);
            end
            done_prev = done;
        end
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (cmd_ready) begin
                @(posedge clock);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        fail_now("cmd_accept");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [3:0] pat);
        int k;
        for (k = 0; k < 400; k++) begin
            if (done_count >= exp_done) break;
            m_ready = pat[k % 4];
            @(posedge clock);
            #1;
        end
        if (k == 400) fail_now("wait_done");
        m_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("done_count", 32'(done_count), 32'(exp_done));
        chk("ext_queue_empty", 32'(exp_ext.size()), 32'd0);
        chk("m_queue_empty", 32'(exp_m.size()), 32'd0);
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int len, input logic [DW-1:0] base);
        ext_t e;
        logic ok;
        for (int i = 0; i < len; i++) begin
            e.wr   = 1'b1;
            e.addr = a + AW'(i);
            e.data = base + DW'(i);
            exp_ext.push_back(e);
            shadow[e.addr] = e.data;
        end
        exp_done++;
        send_cmd(1'b1, a, LW'(len));
        for (int i = 0; i < len; i++) begin
            s_valid = 1'b1;
            s_data  = base + DW'(i);
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clock);
                if (s_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) fail_now("s_ready");
            @(posedge clock);
            #1;
        end
        s_valid = 1'b0;
        s_data  = '0;
        wait_done(4'b1111);
    endtask

    task automatic push_read(input logic [AW-1:0] a, input int len);
        ext_t e;
        for (int i = 0; i < len; i++) begin
            e.wr   = 1'b0;
            e.addr = a + AW'(i);
            e.data = '0;
            exp_ext.push_back(e);
            exp_m.push_back(shadow[e.addr]);
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int len, input logic [3:0] pat,
                              input logic strict);
        strict_lat    = strict;
        rd_seen_burst = 0;
        push_read(a, len);
        exp_done++;
        m_ready = 1'b1;
        send_cmd(1'b0, a, LW'(len));
        wait_done(pat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int dc;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_ext_valid", 32'(ext_valid), 32'd0);
        chk("rst_ext_write", 32'(ext_write), 32'd0);
        chk("rst_ext_addr", 32'(ext_addr), 32'd0);
        chk("rst_ext_wdata", ext_wdata, 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("cmd_ready_out_of_reset", 32'(cmd_ready), 32'd1);

        // Write burst 0x010 len 4, then read it back with m_ready held high
        write_burst(12'h010, 4, 32'hA0);
        read_burst(12'h010, 4, 4'b1111, 1'b1);
        chk("read_back_to_back", 32'(last_rd_cyc - first_rd_cyc), 32'd3);

        // Backpressure: m_ready 1-0-0-1 on a 16-word read
        write_burst(12'h000, 16, 32'h100);
        read_burst(12'h000, 16, 4'b1001, 1'b0);
        chk("read_stalled", 32'(last_rd_cyc - first_rd_cyc > 15), 32'd1);

        // Address wrap-around
        write_burst(12'hFFE, 4, 32'hB0);
        read_burst(12'hFFE, 4, 4'b1111, 1'b1);

        // Zero-length command with a stream beat on offer
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        hs0     = s_hs_count;
        exp_done++;
        send_cmd(1'b1, 12'h123, '0);
        wait_done(4'b1111);
        chk("zero_len_done_latency", 32'(done_cyc - accept_cyc), 32'd1);
        chk("zero_len_no_stream", 32'(s_hs_count - hs0), 32'd0);
        s_valid = 1'b0;
        s_data  = '0;

        // Reset during an 8-word read
        strict_lat    = 1'b0;
        rd_seen_burst = 0;
        push_read(12'h000, 8);
        m_ready = 1'b1;
        send_cmd(1'b0, 12'h000, LW'(8));
        for (int k = 0; k < 100; k++) begin
            if (rd_seen_burst >= 3) break;
            @(posedge clock);
            #1;
        end
        chk("reset_reached_word3", 32'(rd_seen_burst >= 3), 32'd1);
        dc = done_count;
        reset_n = 1'b0;
        #1;
        chk("midrst_ext_valid", 32'(ext_valid), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        exp_ext.delete();
        exp_m.delete();
        wr_cyc_q.delete();
        rd_cyc_q.delete();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (cmd_ready) break;
        end
        chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
        chk("no_done_after_reset", 32'(done_count), 32'(dc));
        @(posedge clock);
        #1;
        read_burst(12'h010, 4, 4'b1111, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
